// File: rtl/top_crg_pkg.sv
// Shared types and limits for the sys/ clock/reset blocks.
package top_crg_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABLE    = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } state_e;

    localparam int unsigned LOCK_LOSS_W = 8;

    localparam int unsigned SYNC_STAGES_MIN  = 2;
    localparam int unsigned SYNC_STAGES_MAX  = 4;
    localparam int unsigned LOCK_STABLE_MIN  = 1;
    localparam int unsigned STAGE_GAP_MIN    = 1;
    localparam int unsigned NUM_STAGES_MIN   = 1;
    localparam int unsigned NUM_STAGES_MAX   = 8;

    // Saturating increment for the lock-loss counter.
    function automatic logic [LOCK_LOSS_W-1:0] sat_inc(input logic [LOCK_LOSS_W-1:0] v);
        return (v == '1) ? v : v + LOCK_LOSS_W'(1);
    endfunction

endpackage

// File: rtl/top_sync.sv
// N-flop synchroniser for a single asynchronous level, cleared by a synchronous reset.
module top_sync
    import top_crg_pkg::*;
#(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
        $error("top_sync: STAGES out of range");
    end

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/top_rst_seq.sv
// Staged reset sequencer driven by PLL lock: debounce lock, release resets in order, abort on loss.
module top_rst_seq
    import top_crg_pkg::*;
#(
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned STAGE_GAP_CYCLES   = 64,
    parameter int unsigned NUM_STAGES         = 3
) (
    input  logic                   FPGA_CLK1_50,
    input  logic                   RESET,
    input  logic                   PLL_LOCKED,
    input  logic                   SW_RST_REQ,
    output logic [NUM_STAGES-1:0]  RST_OUT,
    output logic                   READY,
    output logic [LOCK_LOSS_W-1:0] LOCK_LOSS_CNT,
    output logic [1:0]             STATE
);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("top_rst_seq: SYNC_STAGES out of range");
    end
    if (LOCK_STABLE_CYCLES < LOCK_STABLE_MIN) begin : g_bad_stable
        $error("top_rst_seq: LOCK_STABLE_CYCLES out of range");
    end
    if (STAGE_GAP_CYCLES < STAGE_GAP_MIN) begin : g_bad_gap
        $error("top_rst_seq: STAGE_GAP_CYCLES out of range");
    end
    if (NUM_STAGES < NUM_STAGES_MIN || NUM_STAGES > NUM_STAGES_MAX) begin : g_bad_stages
        $error("top_rst_seq: NUM_STAGES out of range");
    end

    // One counter serves both the stability window and the stage gap.
    localparam int unsigned CNT_SPAN = (LOCK_STABLE_CYCLES > STAGE_GAP_CYCLES) ?
                                       LOCK_STABLE_CYCLES : STAGE_GAP_CYCLES;
    localparam int unsigned CNT_W    = (CNT_SPAN > 1) ? $clog2(CNT_SPAN) : 1;
    localparam int unsigned IDX_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_STAGES - 1);

    logic                   lk;
    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [IDX_W-1:0]       idx_q;
    logic [NUM_STAGES-1:0]  rst_q;
    logic                   ready_q;
    logic [LOCK_LOSS_W-1:0] loss_cnt_q;
    logic [LOCK_LOSS_W-1:0] loss_cnt_d;
    logic                   abort_lock_c;
    logic                   abort_sw_c;

    top_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk_i (FPGA_CLK1_50),
        .rst_i (RESET),
        .d_i   (PLL_LOCKED),
        .q_o   (lk)
    );

    // Abort conditions outside WAIT_LOCK; lock loss takes priority over a software request.
    assign abort_lock_c = (state_q != ST_WAIT_LOCK) && !lk;
    assign abort_sw_c   = (state_q != ST_WAIT_LOCK) && lk && SW_RST_REQ;
    assign loss_cnt_d   = sat_inc(loss_cnt_q);

    // Sequencer FSM with registered outputs.
    always_ff @(posedge FPGA_CLK1_50) begin
        if (RESET) begin
            state_q    <= ST_WAIT_LOCK;
            cnt_q      <= '0;
            idx_q      <= '0;
            rst_q      <= '1;
            ready_q    <= 1'b0;
            loss_cnt_q <= '0;
        end else if (abort_lock_c || abort_sw_c) begin
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
            if (abort_lock_c) begin
                loss_cnt_q <= loss_cnt_d;
            end
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    if (lk) begin
                        state_q <= ST_STABLE;
                        cnt_q   <= '0;
                    end
                end
                ST_STABLE: begin
                    if (cnt_q == STABLE_LAST) begin
                        state_q <= ST_RELEASE;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q <= '0;
                        // Bits clear in ascending order, so a left shift drops the next one.
                        rst_q <= rst_q << 1;
                        idx_q <= idx_q + IDX_W'(1);
                        if (idx_q == IDX_LAST) begin
                            state_q <= ST_RUN;
                            ready_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    rst_q   <= '0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_WAIT_LOCK;
                end
            endcase
        end
    end

    assign RST_OUT       = rst_q;
    assign READY         = ready_q;
    assign LOCK_LOSS_CNT = loss_cnt_q;
    assign STATE         = state_q;

endmodule

// File: tb/tb_top_rst_seq.sv
// Self-checking bench for top_rst_seq: default instance plus a short single-stage instance.
module tb_top_rst_seq;

    logic       clk;
    logic       rst;
    logic       pll;
    logic       sw;

    logic [2:0] rst_out1;
    logic       ready1;
    logic [7:0] cnt1;
    logic [1:0] state1;

    logic [0:0] rst_out2;
    logic       ready2;
    logic [7:0] cnt2;
    logic [1:0] state2;

    int n_chk = 0;
    int n_err = 0;

    top_rst_seq u_dut (
        .FPGA_CLK1_50  (clk),
        .RESET         (rst),
        .PLL_LOCKED    (pll),
        .SW_RST_REQ    (sw),
        .RST_OUT       (rst_out1),
        .READY         (ready1),
        .LOCK_LOSS_CNT (cnt1),
        .STATE         (state1)
    );

    top_rst_seq #(
        .SYNC_STAGES        (3),
        .LOCK_STABLE_CYCLES (4),
        .STAGE_GAP_CYCLES   (1),
        .NUM_STAGES         (1)
    ) u_dut2 (
        .FPGA_CLK1_50  (clk),
        .RESET         (rst),
        .PLL_LOCKED    (pll),
        .SW_RST_REQ    (sw),
        .RST_OUT       (rst_out2),
        .READY         (ready2),
        .LOCK_LOSS_CNT (cnt2),
        .STATE         (state2)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Behavioural model: a "session" starts when the delayed lock is seen high,
    // and every output is a function of the session's age.
    typedef struct {
        int hist[4];
        bit live;
        int age;
        int cnt;
    } mdl_t;

    mdl_t m1;
    mdl_t m2;

    function automatic void mdl_step(inout mdl_t m, input int s, input bit r, input bit p, input bit q);
        bit lkv;
        if (r) begin
            for (int i = 0; i < 4; i++) m.hist[i] = 0;
            m.live = 0;
            m.age  = 0;
            m.cnt  = 0;
            return;
        end
        lkv = (m.hist[s-1] != 0);
        if (m.live && !lkv) begin
            m.live = 0;
            if (m.cnt < 255) m.cnt = m.cnt + 1;
        end else if (m.live && q) begin
            m.live = 0;
        end else if (m.live) begin
            if (m.age < 1000000) m.age = m.age + 1;
        end else if (lkv) begin
            m.live = 1;
            m.age  = 0;
        end
        for (int i = 3; i > 0; i--) m.hist[i] = m.hist[i-1];
        m.hist[0] = int'(p);
    endfunction

    function automatic int m_rel(input mdl_t m, input int lsc, input int g, input int n);
        int r;
        if (!m.live || m.age < lsc) return 0;
        r = (m.age - lsc) / g;
        return (r > n) ? n : r;
    endfunction

    function automatic int m_state(input mdl_t m, input int lsc, input int g, input int n);
        if (!m.live) return 0;
        if (m.age < lsc) return 1;
        if (m_rel(m, lsc, g, n) < n) return 2;
        return 3;
    endfunction

    function automatic int m_mask(input mdl_t m, input int lsc, input int g, input int n);
        int r;
        r = m_rel(m, lsc, g, n);
        return ((1 << n) - 1) & ~((1 << r) - 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model-vs-DUT compare on every cycle, 1 time unit after the edge.
    initial begin
        forever begin
            @(posedge clk);
            mdl_step(m1, 2, rst, pll, sw);
            mdl_step(m2, 3, rst, pll, sw);
            #1;
            chk("m1_rst",   int'(rst_out1), m_mask(m1, 1024, 64, 3));
            chk("m1_ready", int'(ready1),   int'(m_rel(m1, 1024, 64, 3) == 3 && m1.live));
            chk("m1_state", int'(state1),   m_state(m1, 1024, 64, 3));
            chk("m1_cnt",   int'(cnt1),     m1.cnt);
            chk("m2_rst",   int'(rst_out2), m_mask(m2, 4, 1, 1));
            chk("m2_ready", int'(ready2),   int'(m_rel(m2, 4, 1, 1) == 1 && m2.live));
            chk("m2_state", int'(state2),   m_state(m2, 4, 1, 1));
            chk("m2_cnt",   int'(cnt2),     m2.cnt);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Directed scenarios with hand-computed expectations.
    initial begin
        rst = 1'b1;
        pll = 1'b0;
        sw  = 1'b0;
        step(4);
        chk("reset_rst",   int'(rst_out1), 7);
        chk("reset_ready", int'(ready1),   0);
        chk("reset_state", int'(state1),   0);
        chk("reset_cnt",   int'(cnt1),     0);

        // Clean bring-up: edge e1 is the next edge.
        rst = 1'b0;
        pll = 1'b1;
        step(8);
        chk("s1_e8_rst",   int'(rst_out2), 1);
        chk("s1_e8_ready", int'(ready2),   0);
        step(1);
        chk("s1_e9_rst",   int'(rst_out2), 0);
        chk("s1_e9_ready", int'(ready2),   1);
        step(1081);
        chk("up_e1090", int'(rst_out1), 7);
        chk("up_e1090_state", int'(state1), 2);
        step(1);
        chk("up_e1091", int'(rst_out1), 6);
        step(63);
        chk("up_e1154", int'(rst_out1), 6);
        step(1);
        chk("up_e1155", int'(rst_out1), 4);
        step(63);
        chk("up_e1218_ready", int'(ready1), 0);
        step(1);
        chk("up_e1219_rst",   int'(rst_out1), 0);
        chk("up_e1219_ready", int'(ready1),   1);
        chk("up_e1219_state", int'(state1),   3);

        // Lock loss in RUN.
        pll = 1'b0;
        step(2);
        chk("loss_f2_ready", int'(ready1), 1);
        step(1);
        chk("loss_f3_rst",   int'(rst_out1), 7);
        chk("loss_f3_ready", int'(ready1),   0);
        chk("loss_f3_cnt",   int'(cnt1),     1);
        pll = 1'b1;
        step(1218);
        chk("relock_e1218_ready", int'(ready1), 0);
        step(1);
        chk("relock_e1219_ready", int'(ready1), 1);

        // Software request in RUN, then again in RELEASE.
        sw = 1'b1;
        step(1);
        sw = 1'b0;
        chk("swrun_rst", int'(rst_out1), 7);
        chk("swrun_cnt", int'(cnt1),     1);
        step(1088);
        chk("swrun_s1088", int'(rst_out1), 7);
        step(1);
        chk("swrun_s1089", int'(rst_out1), 6);
        step(10);
        sw = 1'b1;
        step(1);
        sw = 1'b0;
        chk("swrel_rst",   int'(rst_out1), 7);
        chk("swrel_cnt",   int'(cnt1),     1);
        chk("swrel_state", int'(state1),   0);
        step(1088);
        chk("swrel_s1088", int'(rst_out1), 7);
        step(1);
        chk("swrel_s1089", int'(rst_out1), 6);
        step(64);
        chk("swrel_s1153", int'(rst_out1), 4);
        step(63);
        chk("swrel_s1216_ready", int'(ready1), 0);
        step(1);
        chk("swrel_s1217_rst",   int'(rst_out1), 0);
        chk("swrel_s1217_ready", int'(ready1),   1);

        // Software request in the cycle the synchronised lock is low: counted as a loss.
        pll = 1'b0;
        step(2);
        sw = 1'b1;
        step(1);
        sw = 1'b0;
        chk("both_cnt", int'(cnt1),     2);
        chk("both_rst", int'(rst_out1), 7);

        // Repeated short lock windows that reach STABLE, to saturate the counter.
        for (int i = 0; i < 300; i++) begin
            pll = 1'b1;
            step(4);
            pll = 1'b0;
            step(4);
        end
        chk("sat_cnt", int'(cnt1), 255);

        // Lock glitch during the stability window.
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        chk("glitch_cnt0", int'(cnt1), 0);
        pll = 1'b1;
        step(500);
        pll = 1'b0;
        step(10);
        chk("glitch_cnt1", int'(cnt1),     1);
        chk("glitch_rst",  int'(rst_out1), 7);
        pll = 1'b1;
        step(1090);
        chk("glitch_e1090", int'(rst_out1), 7);
        step(1);
        chk("glitch_e1091", int'(rst_out1), 6);
        chk("glitch_state", int'(state1),   2);

        // Reset while in RELEASE.
        rst = 1'b1;
        step(1);
        chk("midrst_rst",   int'(rst_out1), 7);
        chk("midrst_ready", int'(ready1),   0);
        chk("midrst_state", int'(state1),   0);
        chk("midrst_cnt",   int'(cnt1),     0);
        rst = 1'b0;
        step(20);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
